// File: rtl/unidade_controle_mc.sv
// Multicycle control FSM for the 8-bit datapath: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects and the PC/IR/register-file/data-memory write enables.
module unidade_controle_mc #(
    parameter int OPW       = 4,
    parameter int WIDTH_SEL = 2
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Run,
    input  logic [OPW-1:0]       Opcode,
    input  logic                 Zero,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 SelRegDst,
    output logic                 SelALUB,
    output logic [WIDTH_SEL-1:0] SelWB,
    output logic [WIDTH_SEL-1:0] SelPC,
    output logic [1:0]           ALUOp,
    output logic                 Halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
    localparam logic [OPW-1:0] OP_LW   = OPW'(5);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(7);
    localparam logic [OPW-1:0] OP_J    = OPW'(8);
    localparam logic [OPW-1:0] OP_NOPL = OPW'(9);
    localparam logic [OPW-1:0] OP_NOPH = OPW'(14);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        SelRegDst = 1'b0;
        SelALUB   = 1'b0;
        SelWB     = '0;
        SelPC     = '0;
        ALUOp     = 2'b00;
        Halted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = Opcode;
                if (Opcode == OP_HALT)
                    state_d = S_HALT;
                else if (Opcode >= OP_NOPL && Opcode <= OP_NOPH)
                    state_d = S_FETCH;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (op_q <= OP_OR) begin
                    ALUOp   = op_q[1:0];
                    state_d = S_WB;
                end else if (op_q == OP_ADDI) begin
                    SelALUB = 1'b1;
                    state_d = S_WB;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    SelALUB = 1'b1;
                    state_d = S_MEM;
                end else if (op_q == OP_BEQ) begin
                    ALUOp = 2'b01;
                    if (Zero) begin
                        PCWrite = 1'b1;
                        SelPC   = WIDTH_SEL'(1);
                    end
                end else if (op_q == OP_J) begin
                    PCWrite = 1'b1;
                    SelPC   = WIDTH_SEL'(2);
                end
            end
            S_MEM: begin
                state_d = S_FETCH;
                if (op_q == OP_LW) begin
                    MemRead = 1'b1;
                    state_d = S_WB;
                end else if (op_q == OP_SW) begin
                    MemWrite = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                // R-type writes rd; ADDI/LW write rt; only LW takes memory data
                if (op_q <= OP_OR) SelRegDst = 1'b1;
                if (op_q == OP_LW) SelWB = WIDTH_SEL'(1);
                state_d = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Self-checking bench for unidade_controle_mc: directed and random instruction streams
// compared cycle by cycle against a per-instruction step table.
module tb_unidade_controle_mc;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [3:0] Opcode;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
    logic       SelRegDst, SelALUB, Halted;
    logic [1:0] SelWB, SelPC, ALUOp;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       rd;
        logic       alub;
        logic [1:0] wb;
        logic [1:0] pc;
        logic [1:0] aluop;
        logic       halted;
    } out_t;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    unidade_controle_mc #(.OPW(4), .WIDTH_SEL(2)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .SelRegDst(SelRegDst),
        .SelALUB  (SelALUB),
        .SelWB    (SelWB),
        .SelPC    (SelPC),
        .ALUOp    (ALUOp),
        .Halted   (Halted)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Cycle count of one instruction, FETCH included
    function automatic int unsigned instr_len(input logic [3:0] op);
        if (op <= 4'd4) return 4;
        if (op == 4'd5) return 5;
        if (op == 4'd6) return 4;
        if (op == 4'd7 || op == 4'd8) return 3;
        return 2;
    endfunction

    // Expected outputs in step k of an instruction (0 = fetch, 1 = decode)
    function automatic out_t exp_step(input logic [3:0] op, input int unsigned k, input logic z);
        out_t e;
        e = '0;
        if (k == 0) begin
            e.irw = 1'b1;
            e.pcw = 1'b1;
        end else if (k >= 2) begin
            case (op)
                4'd0, 4'd1, 4'd2, 4'd3: begin
                    if (k == 2) e.aluop = op[1:0];
                    else begin e.rw = 1'b1; e.rd = 1'b1; end
                end
                4'd4: begin
                    if (k == 2) e.alub = 1'b1;
                    else e.rw = 1'b1;
                end
                4'd5: begin
                    if (k == 2) e.alub = 1'b1;
                    else if (k == 3) e.mr = 1'b1;
                    else begin e.rw = 1'b1; e.wb = 2'b01; end
                end
                4'd6: begin
                    if (k == 2) e.alub = 1'b1;
                    else e.mw = 1'b1;
                end
                4'd7: begin
                    e.aluop = 2'b01;
                    if (z) begin e.pcw = 1'b1; e.pc = 2'b01; end
                end
                4'd8: begin
                    e.pcw = 1'b1;
                    e.pc  = 2'b10;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input out_t e);
        out_t obs;
        obs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, SelRegDst, SelALUB,
               SelWB, SelPC, ALUOp, Halted};
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
        n_cmp++;
        assert (($countones({obs.rw, obs.mw, obs.irw}) <= 1) && !(obs.mr && obs.mw)) else begin
            n_fail++;
            $error("FAIL %s_invariant observed=%b expected=exclusive_strobes", tag, obs);
        end
    endtask

    // Entered just after the edge that puts the FSM in FETCH; leaves it at the next FETCH.
    // zmode: 0/1 fixed Zero, 2 random. From EXEC on, Opcode is driven with alt.
    task automatic run_instr(input string tag, input logic [3:0] op, input int unsigned zmode,
                             input logic [3:0] alt);
        int unsigned len;
        len = instr_len(op);
        Opcode = op;
        for (int unsigned k = 0; k < len; k++) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            Run  = 1'($urandom_range(0, 1));
            if (k >= 2) Opcode = alt;
            @(negedge Clock);
            check($sformatf("%s_op%0d_k%0d", tag, op, k), exp_step(op, k, Zero));
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        out_t zero_v;
        out_t halt_v;
        logic [3:0] rop;
        zero_v = '0;
        halt_v = '0;
        halt_v.halted = 1'b1;

        Resetn = 1'b0;
        Run    = 1'b0;
        Opcode = 4'd0;
        Zero   = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset", zero_v);

        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        check("idle_run0", zero_v);
        Run = 1'b1;
        @(posedge Clock);
        #1;

        run_instr("add",     4'd0, 2, 4'd0);
        run_instr("lw",      4'd5, 2, 4'd5);
        run_instr("sw",      4'd6, 2, 4'd6);
        run_instr("beq_z1",  4'd7, 1, 4'd7);
        run_instr("beq_z0",  4'd7, 0, 4'd7);
        run_instr("add_hold",4'd0, 2, 4'd6);
        run_instr("nop",     4'd9, 2, 4'd9);
        run_instr("j",       4'd8, 2, 4'd8);
        run_instr("addi",    4'd4, 2, 4'd4);
        run_instr("or",      4'd3, 2, 4'd3);
        run_instr("nop_e",   4'd14, 2, 4'd14);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 14));
            run_instr("rnd", rop, 2, 4'($urandom_range(0, 15)));
        end

        // HALT: fetch, decode, then held regardless of Run
        Opcode = 4'd15;
        @(negedge Clock);
        check("halt_fetch", exp_step(4'd15, 0, 1'b0));
        @(posedge Clock);
        #1;
        Opcode = 4'd15;
        @(negedge Clock);
        check("halt_decode", zero_v);
        @(posedge Clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            Run    = 1'(i & 1);
            Opcode = 4'($urandom_range(0, 15));
            Zero   = 1'($urandom_range(0, 1));
            @(negedge Clock);
            check($sformatf("halted_%0d", i), halt_v);
            @(posedge Clock);
            #1;
        end

        Resetn = 1'b0;
        #1;
        check("halt_reset", zero_v);
        Resetn = 1'b1;
        Run    = 1'b1;
        @(posedge Clock);
        #1;

        // LW interrupted by reset while in MEM
        Opcode = 4'd5;
        for (int unsigned k = 0; k < 3; k++) begin
            Zero = 1'($urandom_range(0, 1));
            @(negedge Clock);
            check($sformatf("lw_rst_k%0d", k), exp_step(4'd5, k, Zero));
            @(posedge Clock);
            #1;
        end
        @(negedge Clock);
        check("lw_rst_mem", exp_step(4'd5, 3, Zero));
        #2;
        Resetn = 1'b0;
        #1;
        check("rst_async", zero_v);
        @(posedge Clock);
        #1;
        check("rst_held", zero_v);
        Resetn = 1'b1;
        Run    = 1'b0;
        @(posedge Clock);
        #1;
        check("rst_idle", zero_v);
        Run    = 1'b1;
        Opcode = 4'd0;
        @(posedge Clock);
        #1;
        check("restart_fetch", exp_step(4'd0, 0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
